// File: rtl/ahb_vga_wbuf_if.sv
// AHB-Lite slave bus plus console/image sink handshakes for the VGA write buffer.
interface ahb_vga_wbuf_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 14
);
  logic              HSEL;
  logic              HWRITE;
  logic              HREADY;
  logic [1:0]        HTRANS;
  logic [31:0]       HADDR;
  logic [31:0]       HWDATA;
  logic              HREADYOUT;
  logic [31:0]       HRDATA;
  logic              HRESP;
  logic              con_valid;
  logic              con_ready;
  logic [DATA_W-1:0] con_data;
  logic              img_valid;
  logic              img_ready;
  logic [ADDR_W-1:0] img_addr;
  logic [DATA_W-1:0] img_data;
  logic [9:0]        split_x;
  logic              irq;

  modport slave (
    input  HSEL, HWRITE, HREADY, HTRANS, HADDR, HWDATA, con_ready, img_ready,
    output HREADYOUT, HRDATA, HRESP, con_valid, con_data,
           img_valid, img_addr, img_data, split_x, irq
  );

  modport master (
    output HSEL, HWRITE, HREADY, HTRANS, HADDR, HWDATA, con_ready, img_ready,
    input  HREADYOUT, HRDATA, HRESP, con_valid, con_data,
           img_valid, img_addr, img_data, split_x, irq
  );
endinterface

// File: rtl/ahb_vga_wbuf.sv
// AHB-Lite write buffer for a VGA console/image pair: console and image writes are
// queued in bus order and drained to whichever sink the head entry targets.
module ahb_vga_wbuf #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SPLIT_RST = 240
) (
  input  logic          HCLK,
  input  logic          HRESET,
  ahb_vga_wbuf_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              img;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              ph_valid_q, ph_valid_d;
  logic              ph_write_q, ph_write_d;
  logic [23:0]       ph_addr_q, ph_addr_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              hready_q, hready_d;
  logic [31:0]       hrdata_q, hrdata_d;
  logic [9:0]        split_q, split_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic              con_valid_q, con_valid_d;
  logic              img_valid_q, img_valid_d;
  logic [DATA_W-1:0] con_data_q, con_data_d;
  logic [ADDR_W-1:0] img_addr_q, img_addr_d;
  logic [DATA_W-1:0] img_data_q, img_data_d;

  logic              push_req, push, pop, full, ctrl_wr, flush, nxt_push_req;
  entry_t            new_entry, head_d;
  logic [31:0]       status_d, ctrl_d;
  logic              unused_bits;

  always_comb begin
    // The captured address phase is held while the bus is stalled.
    ph_valid_d = ph_valid_q;
    ph_write_d = ph_write_q;
    ph_addr_d  = ph_addr_q;
    if (bus.HREADY) begin
      ph_valid_d = bus.HSEL & bus.HTRANS[1];
      ph_write_d = bus.HWRITE;
      ph_addr_d  = bus.HADDR[23:0];
    end

    push_req = ph_valid_q & ph_write_q & (ph_addr_q[23] | (ph_addr_q[3:2] == 2'd0));
    ctrl_wr  = ph_valid_q & ph_write_q & ~ph_addr_q[23] & (ph_addr_q[3:2] == 2'd2);
    full     = (count_q == CNT_W'(DEPTH));
    push     = push_req & ~full;
    pop      = (con_valid_q & bus.con_ready) | (img_valid_q & bus.img_ready);
    flush    = ctrl_wr & bus.HWDATA[16];

    new_entry.img  = ph_addr_q[23];
    new_entry.addr = ph_addr_q[23] ? ph_addr_q[ADDR_W+1:2] : '0;
    new_entry.data = bus.HWDATA[DATA_W-1:0];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Flush wins over a same-cycle pop; the popped entry is simply discarded.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    split_d  = split_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      split_d  = bus.HWDATA[9:0];
      irq_en_d = bus.HWDATA[17];
    end
    irq_d = irq_en_q & (count_q == '0);

    // Stall the next data phase only if it is a queued write landing on a full FIFO.
    nxt_push_req = ph_valid_d & ph_write_d & (ph_addr_d[23] | (ph_addr_d[3:2] == 2'd0));
    hready_d     = ~(nxt_push_req & (count_d == CNT_W'(DEPTH)));

    status_d = {count_d == CNT_W'(DEPTH), count_d == '0, irq_en_d, 20'd0, 9'(count_d)};
    ctrl_d   = {14'd0, irq_en_d, 7'd0, split_d};
    hrdata_d = '0;
    if (ph_valid_d & ~ph_write_d & ~ph_addr_d[23]) begin
      case (ph_addr_d[1+2:2])
        2'd1:    hrdata_d = status_d;
        2'd2:    hrdata_d = ctrl_d;
        default: hrdata_d = '0;
      endcase
    end

    head_d      = mem_d[rd_ptr_d];
    con_valid_d = (count_d != '0) & ~head_d.img;
    img_valid_d = (count_d != '0) & head_d.img;
    con_data_d  = head_d.data;
    img_addr_d  = head_d.addr;
    img_data_d  = head_d.data;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ph_valid_q  <= 1'b0;
      ph_write_q  <= 1'b0;
      ph_addr_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hready_q    <= 1'b1;
      hrdata_q    <= '0;
      split_q     <= 10'(SPLIT_RST);
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      con_valid_q <= 1'b0;
      img_valid_q <= 1'b0;
      con_data_q  <= '0;
      img_addr_q  <= '0;
      img_data_q  <= '0;
    end else begin
      ph_valid_q  <= ph_valid_d;
      ph_write_q  <= ph_write_d;
      ph_addr_q   <= ph_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hready_q    <= hready_d;
      hrdata_q    <= hrdata_d;
      split_q     <= split_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      con_valid_q <= con_valid_d;
      img_valid_q <= img_valid_d;
      con_data_q  <= con_data_d;
      img_addr_q  <= img_addr_d;
      img_data_q  <= img_data_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge HCLK) mem_q <= mem_d;

  assign bus.HREADYOUT = hready_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.HRESP     = 1'b0;
  assign bus.con_valid = con_valid_q;
  assign bus.con_data  = con_data_q;
  assign bus.img_valid = img_valid_q;
  assign bus.img_addr  = img_addr_q;
  assign bus.img_data  = img_data_q;
  assign bus.split_x   = split_q;
  assign bus.irq       = irq_q;

  assign unused_bits = ^{bus.HADDR, bus.HWDATA, bus.HTRANS, ph_addr_q};
endmodule

// File: doc/ahb_vga_wbuf.md
AHB_VGA_WBUF -- requirements
Module: ahb_vga_wbuf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel/character data width (1..32).
REQ-002 SHALL have parameter ADDR_W, default 14, image word-address width (1..21).
REQ-003 SHALL have parameter DEPTH, default 8, write-buffer entries (power of 2, 2..256).
REQ-004 SHALL have parameter SPLIT_RST, default 240, reset value of console/image split column.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 HCLK  in  1  clock; all logic on rising edge.
REQ-007 HRESET  in  1  synchronous active-high reset.
REQ-008 HSEL, HWRITE, HREADY  in  1 each  AHB-Lite slave select, write, bus ready.
REQ-009 HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
REQ-010 HADDR, HWDATA  in  32 each  address, write data.
REQ-011 HREADYOUT  out  1  slave ready; HRDATA  out  32  read data; HRESP  out  1  tied 0.
REQ-012 con_valid/con_ready  out/in  1  console sink handshake; con_data  out  DATA_W.
REQ-013 img_valid/img_ready  out/in  1  image sink handshake; img_addr  out  ADDR_W; img_data  out  DATA_W.
REQ-014 split_x  out  10  console/image boundary column for display mux.
REQ-015 irq  out  1  buffer-empty interrupt, level.

Function
REQ-016 Address phase SHALL be captured when HREADY & HSEL & HTRANS[1]; else the captured phase is idle.
REQ-017 Decode on captured HADDR[23:0]: HADDR[23]=1 image write, img_addr=HADDR[ADDR_W+1:2]; HADDR[23]=0 register space, HADDR[3:2]: 0 CONSOLE (WO), 1 STATUS (RO), 2 CTRL (RW), 3 reserved (read 0, write ignored).
REQ-018 Data-phase write to CONSOLE or image SHALL push {type, addr, HWDATA[DATA_W-1:0]} into a single in-order FIFO.
REQ-019 Push SHALL occur only when count < DEPTH; at count == DEPTH HREADYOUT SHALL be 0 until an entry is popped, push then completes with HREADYOUT=1 the following cycle; no write is ever dropped.
REQ-020 HREADYOUT SHALL be 1 in every other case (reads, CTRL writes, idle).
REQ-021 Head entry SHALL drive con_valid (console type) or img_valid (image type), never both; both 0 when empty.
REQ-022 Pop SHALL occur on a cycle where the asserted valid meets its ready; sink data/addr SHALL stay stable while valid & !ready.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-024 STATUS read SHALL return bit31 full, bit30 empty, bit29 irq_en, bits[8:0] count, others 0.
REQ-025 CTRL write: bits[9:0] -> split_x, bit16 flush (self-clearing, not stored), bit17 -> irq_en; CTRL read returns {irq_en at bit17, split_x}.
REQ-026 Flush SHALL clear count and pointers the cycle after the CTRL data phase; a pop in that cycle is discarded; valids drop to 0.
REQ-027 HRDATA SHALL be valid in the data phase of a read and 0 otherwise.
REQ-028 irq SHALL equal irq_en & empty, registered (one cycle after condition).
REQ-029 Write latency: entry visible on sink valid the cycle after the write data phase when FIFO was empty.

Reset
REQ-030 On HRESET: count=0, pointers=0, con_valid=img_valid=0, HREADYOUT=1, HRDATA=0, split_x=SPLIT_RST, irq_en=0, irq=0, captured phase idle.
REQ-031 Reset mid-stall SHALL abandon the pending push and return HREADYOUT=1 the next cycle.

Verification
REQ-032 Write 0x41 to 0x000000, con_ready=1 -> con_valid one cycle with con_data=0x41, img_valid=0.
REQ-033 Write 0x3C to 0x800010, img_ready=0 for 5 cycles -> img_valid held, img_addr=0x004, img_data=0x3C stable, popped on ready.
REQ-034 Sinks not ready, 9 consecutive console writes (DEPTH=8) -> 9th sees HREADYOUT=0; raise con_ready -> stall ends, 9 entries drain in order.
REQ-035 Mixed console/image writes, sinks alternately stalled -> output order equals write order; STATUS count matches pushes minus pops each cycle.
REQ-036 CTRL write 0x0003_0100 with 4 entries queued -> split_x=0x100, FIFO empty next cycle, STATUS reads 0x6000_0000, irq=1 one cycle later.
REQ-037 HRESET asserted during full stall -> next cycle HREADYOUT=1, STATUS=0x4000_0000, split_x=240.
